// File: rtl/weight_load_ctrl.sv
// -----------------------------------------------------------------------------
// weight_load_ctrl
//
// Purpose:
//   Streams the kernel weights of one conv layer from on-chip weight memory
//   into the KERNEL_SIZE x KERNEL_SIZE weight shift window feeding the PE
//   array.  Kernels are visited output channel outer, input channel inner.
//   For each kernel, KERNEL_SIZE*KERNEL_SIZE contiguous words are read, each
//   is forwarded with a one-cycle shift strobe, and kernel_ready is then held
//   until the conv engine signals kernel_consume.
//
// Optional build macro:
//   WLC_BIAS_EN - when defined, one bias word is stored after the last kernel
//                 of every output channel block.  It is read after that
//                 kernel's taps and presented on bias_out/bias_valid.  It never
//                 reaches the shift window.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle layer start, honoured only when idle
//   in_ch, out_ch   channel counts, latched on start
//   base_addr       address of the layer's first weight, latched on start
//   w_rd_en/w_addr  weight memory read request
//   w_rdata         weight memory read data, valid the cycle after w_rd_en
//   w_dout/w_shift  weight word and shift strobe to the window
//   kernel_ready    a complete kernel is resident in the window
//   kernel_consume  conv engine is finished with the resident kernel
//   cur_oc, cur_ic  channel coordinates of the resident kernel
//   busy            controller is not idle
//   done            one-cycle pulse once the last kernel has been consumed
//   bias_out        bias word (WLC_BIAS_EN only)
//   bias_valid      one-cycle bias qualifier (WLC_BIAS_EN only)
// -----------------------------------------------------------------------------
module weight_load_ctrl #(
   parameter int DWIDTH      = 16,
   parameter int KERNEL_SIZE = 3,
   parameter int ADDR_WIDTH  = 12,
   parameter int CH_WIDTH    = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [CH_WIDTH-1:0]   in_ch,
   input  logic [CH_WIDTH-1:0]   out_ch,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   output logic                  w_rd_en,
   output logic [ADDR_WIDTH-1:0] w_addr,
   input  logic [DWIDTH-1:0]     w_rdata,
   output logic [DWIDTH-1:0]     w_dout,
   output logic                  w_shift,
   output logic                  kernel_ready,
   input  logic                  kernel_consume,
   output logic [CH_WIDTH-1:0]   cur_oc,
   output logic [CH_WIDTH-1:0]   cur_ic,
   output logic                  busy,
   output logic                  done
`ifdef WLC_BIAS_EN
   ,
   output logic [DWIDTH-1:0]     bias_out,
   output logic                  bias_valid
`endif
);

   localparam int TAPS  = KERNEL_SIZE * KERNEL_SIZE;
   // One spare count so the bias read can be issued after the last tap.
   localparam int TAP_W = $clog2(TAPS + 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DRAIN,
      S_READY,
      S_NEXT,
      S_DONE
   } state_t;

   state_t                r_state;
   logic [CH_WIDTH-1:0]   r_in_ch;
   logic [CH_WIDTH-1:0]   r_out_ch;
   logic [CH_WIDTH-1:0]   r_ic;
   logic [CH_WIDTH-1:0]   r_oc;
   logic [ADDR_WIDTH-1:0] r_ptr;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [TAP_W-1:0]      r_tap;
   logic                  r_rd_en;
   logic                  r_ready;
   logic                  r_busy;
   logic                  r_done;
   logic                  r_vld_p1;

   logic                  w_ic_last;
   logic                  w_oc_last;
   logic [TAP_W-1:0]      w_limit;

   assign w_ic_last = (r_ic == r_in_ch - 1'b1);
   assign w_oc_last = (r_oc == r_out_ch - 1'b1);

`ifdef WLC_BIAS_EN
   logic r_rd_bias;
   logic r_bias_vld_p1;

   // The last input channel of an oc block carries one extra (bias) read.
   assign w_limit = w_ic_last ? TAP_W'(TAPS + 1) : TAP_W'(TAPS);
`else
   assign w_limit = TAP_W'(TAPS);
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_in_ch  <= '0;
         r_out_ch <= '0;
         r_ic     <= '0;
         r_oc     <= '0;
         r_ptr    <= '0;
         r_addr   <= '0;
         r_tap    <= '0;
         r_rd_en  <= 1'b0;
         r_ready  <= 1'b0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_vld_p1 <= 1'b0;
`ifdef WLC_BIAS_EN
         r_rd_bias     <= 1'b0;
         r_bias_vld_p1 <= 1'b0;
`endif
      end else begin
         // ---- stage p1: read data returns from memory ----
`ifdef WLC_BIAS_EN
         r_vld_p1      <= r_rd_en & ~r_rd_bias;
         r_bias_vld_p1 <= r_rd_en & r_rd_bias;
`else
         r_vld_p1      <= r_rd_en;
`endif

         // ---- stage p0: read request sequencing ----
         case (r_state)
            S_IDLE: begin
               r_rd_en <= 1'b0;
               if (start) begin
                  r_in_ch  <= in_ch;
                  r_out_ch <= out_ch;
                  r_ic     <= '0;
                  r_oc     <= '0;
                  r_busy   <= 1'b1;
                  if (in_ch == '0 || out_ch == '0) begin
                     r_ptr   <= base_addr;
                     r_state <= S_DONE;
                  end else begin
                     // First read goes out on this edge so w_rd_en is seen
                     // the cycle right after start.
                     r_rd_en <= 1'b1;
                     r_addr  <= base_addr;
                     r_ptr   <= base_addr + 1'b1;
                     r_tap   <= TAP_W'(1);
`ifdef WLC_BIAS_EN
                     r_rd_bias <= 1'b0;
`endif
                     r_state <= S_FETCH;
                  end
               end
            end

            S_FETCH: begin
               if (r_tap < w_limit) begin
                  r_rd_en <= 1'b1;
                  r_addr  <= r_ptr;
                  r_ptr   <= r_ptr + 1'b1;
                  r_tap   <= r_tap + 1'b1;
`ifdef WLC_BIAS_EN
                  // Only the read following the last tap can be the bias.
                  r_rd_bias <= (r_tap == TAP_W'(TAPS));
`endif
               end else begin
                  r_rd_en <= 1'b0;
`ifdef WLC_BIAS_EN
                  r_rd_bias <= 1'b0;
`endif
                  r_state <= S_DRAIN;
               end
            end

            S_DRAIN: begin
               // Final word is being shifted this cycle.
               r_ready <= 1'b1;
               r_state <= S_READY;
            end

            S_READY: begin
               if (kernel_consume) begin
                  r_ready <= 1'b0;
                  r_state <= S_NEXT;
               end
            end

            S_NEXT: begin
               if (!w_ic_last || !w_oc_last) begin
                  if (!w_ic_last) begin
                     r_ic <= r_ic + 1'b1;
                  end else begin
                     r_ic <= '0;
                     r_oc <= r_oc + 1'b1;
                  end
                  // Pointer carries on contiguously into the next kernel.
                  r_rd_en <= 1'b1;
                  r_addr  <= r_ptr;
                  r_ptr   <= r_ptr + 1'b1;
                  r_tap   <= TAP_W'(1);
`ifdef WLC_BIAS_EN
                  r_rd_bias <= 1'b0;
`endif
                  r_state <= S_FETCH;
               end else begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end

            S_DONE: begin
               // Arriving from NEXT the pulse is already up; arriving
               // straight from IDLE (empty layer) it is raised here first.
               if (r_done) begin
                  r_done  <= 1'b0;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_done <= 1'b1;
               end
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign w_rd_en      = r_rd_en;
   assign w_addr       = r_addr;
   assign w_shift      = r_vld_p1;
   // The memory's output register is the data stage aligned with w_shift;
   // the word is gated so the window input is quiet between strobes.
   assign w_dout       = r_vld_p1 ? w_rdata : '0;
   assign kernel_ready = r_ready;
   assign cur_oc       = r_oc;
   assign cur_ic       = r_ic;
   assign busy         = r_busy;
   assign done         = r_done;

`ifdef WLC_BIAS_EN
   assign bias_valid = r_bias_vld_p1;
   assign bias_out   = r_bias_vld_p1 ? w_rdata : '0;
`endif

endmodule

// File: tb/tb_weight_load_ctrl.sv
module tb_weight_load_ctrl;

   localparam int DW   = 16;
   localparam int K    = 3;
   localparam int AW   = 12;
   localparam int CW   = 6;
   localparam int TAPS = K * K;
`ifdef WLC_BIAS_EN
   localparam bit BIAS = 1'b1;
`else
   localparam bit BIAS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [CW-1:0] in_ch = '0;
   logic [CW-1:0] out_ch = '0;
   logic [AW-1:0] base_addr = '0;
   logic          w_rd_en;
   logic [AW-1:0] w_addr;
   logic [DW-1:0] w_rdata = '0;
   logic [DW-1:0] w_dout;
   logic          w_shift;
   logic          kernel_ready;
   logic          kernel_consume = 1'b0;
   logic [CW-1:0] cur_oc;
   logic [CW-1:0] cur_ic;
   logic          busy;
   logic          done;
`ifdef WLC_BIAS_EN
   logic [DW-1:0] bias_out;
   logic          bias_valid;
`endif

   weight_load_ctrl #(
      .DWIDTH(DW), .KERNEL_SIZE(K), .ADDR_WIDTH(AW), .CH_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .in_ch(in_ch), .out_ch(out_ch),
      .base_addr(base_addr), .w_rd_en(w_rd_en), .w_addr(w_addr),
      .w_rdata(w_rdata), .w_dout(w_dout), .w_shift(w_shift),
      .kernel_ready(kernel_ready), .kernel_consume(kernel_consume),
      .cur_oc(cur_oc), .cur_ic(cur_ic), .busy(busy), .done(done)
`ifdef WLC_BIAS_EN
      , .bias_out(bias_out), .bias_valid(bias_valid)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Weight memory: mem[i] = i, registered read (data valid one cycle later).
   logic [DW-1:0] mem [0:(1<<AW)-1];
   initial for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
   always @(posedge clk) if (w_rd_en) w_rdata <= mem[w_addr];

   // Observed traffic.
   int q_rd[$];
   int q_sh[$];
   int q_bias[$];
   always @(negedge clk) begin
      if (w_rd_en) q_rd.push_back(int'(w_addr));
      if (w_shift) q_sh.push_back(int'(w_dout));
`ifdef WLC_BIAS_EN
      if (bias_valid) q_bias.push_back(int'(bias_out));
`endif
   end

   int checks = 0;
   int failures = 0;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   typedef struct {
      int ic;
      int oc;
      int base;
      int hold;
      bit poke;
      int exp_shifts;
   } vec_t;

   // Runs one layer and compares every observation with a model built from
   // the layer description: kernel list, address stream, data stream.
   task automatic run_layer(input int ic, input int oc, input int base,
                            input int hold, input bit poke, input int exp_shifts);
      int exp_rd[$];
      int exp_sh[$];
      int exp_bias[$];
      int exp_k[$];
      int got_k[$];
      int got_ksh[$];
      int ptr, t0, err, viol;
      int first_lat = -1;
      int done_lat  = -1;
      int cons_cyc  = -1;
      bit fin = 1'b0;

      ptr = base;
      for (int o = 0; o < oc; o++) begin
         for (int i = 0; i < ic; i++) begin
            exp_k.push_back(o * 64 + i);
            for (int t = 0; t < TAPS; t++) begin
               exp_rd.push_back(ptr % (1 << AW));
               exp_sh.push_back(int'(mem[ptr % (1 << AW)]));
               ptr++;
            end
            if (BIAS && i == ic - 1) begin
               exp_rd.push_back(ptr % (1 << AW));
               exp_bias.push_back(int'(mem[ptr % (1 << AW)]));
               ptr++;
            end
         end
      end

      viol = 0;
      @(negedge clk);
      q_rd.delete(); q_sh.delete(); q_bias.delete();
      in_ch = CW'(ic); out_ch = CW'(oc); base_addr = AW'(base);
      start = 1'b1;
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;

      for (int n = 0; n < 4000 && !fin; n++) begin
         if (poke && cyc == t0 + 3) begin
            // Ignored: consume outside READY, start while busy.
            kernel_consume = 1'b1; start = 1'b1; in_ch = CW'(ic + 1);
            base_addr = AW'(base + 100);
         end else if (poke && cyc == t0 + 4) begin
            kernel_consume = 1'b0; start = 1'b0;
         end
         if (kernel_ready) begin
            if (first_lat < 0) first_lat = cyc - t0;
            if (!busy) viol++;
            got_k.push_back(int'(cur_oc) * 64 + int'(cur_ic));
            got_ksh.push_back(q_sh.size());
            for (int h = 0; h < hold; h++) begin
               @(negedge clk);
               if (!kernel_ready || w_rd_en || w_shift) viol++;
            end
            kernel_consume = 1'b1;
            cons_cyc = cyc;
            @(negedge clk);
            kernel_consume = 1'b0;
            if (kernel_ready) viol++;
         end
         if (done) begin
            done_lat = cyc - ((cons_cyc < 0) ? t0 : cons_cyc);
            fin = 1'b1;
         end else begin
            @(negedge clk);
         end
      end

      check("layer_finished", int'(fin), 1);
      check("done_latency", done_lat, 2);
      check("num_reads", q_rd.size(), exp_rd.size());
      check("num_shifts", q_sh.size(), exp_shifts);
      err = 0;
      for (int i = 0; i < q_rd.size() && i < exp_rd.size(); i++)
         if (q_rd[i] != exp_rd[i]) err++;
      check("read_addr_errors", err, 0);
      err = 0;
      for (int i = 0; i < q_sh.size() && i < exp_sh.size(); i++)
         if (q_sh[i] != exp_sh[i]) err++;
      check("shift_data_errors", err, 0);
      check("num_kernels", got_k.size(), exp_k.size());
      err = 0;
      for (int i = 0; i < got_k.size() && i < exp_k.size(); i++)
         if (got_k[i] != exp_k[i]) err++;
      for (int i = 0; i < got_ksh.size(); i++)
         if (got_ksh[i] != TAPS * (i + 1)) err++;
      check("kernel_order_errors", err, 0);
      if (exp_k.size() > 0)
         check("first_ready_latency", first_lat,
               TAPS + 2 + ((BIAS && ic == 1) ? 1 : 0));
      check("ready_hold_violations", viol, 0);
      check("num_bias", q_bias.size(), exp_bias.size());
      err = 0;
      for (int i = 0; i < q_bias.size() && i < exp_bias.size(); i++)
         if (q_bias[i] != exp_bias[i]) err++;
      check("bias_data_errors", err, 0);
      @(negedge clk);
      check("busy_after_done", int'(busy), 0);
   endtask

   vec_t tbl[7];

   initial begin
      tbl[0] = '{1, 1, 'h010, 0,  1'b0, 9};
      tbl[1] = '{2, 3, 'h100, 0,  1'b0, 54};
      tbl[2] = '{1, 2, 'h020, 20, 1'b1, 18};
      tbl[3] = '{3, 0, 'h030, 0,  1'b0, 0};
      tbl[4] = '{0, 2, 'h040, 0,  1'b0, 0};
      tbl[5] = '{1, 1, 'hFFC, 0,  1'b0, 9};
      tbl[6] = '{2, 1, 'h000, 0,  1'b0, 18};

      // Reset state.
      repeat (2) @(negedge clk);
      check("rst_rd_en", int'(w_rd_en), 0);
      check("rst_shift", int'(w_shift), 0);
      check("rst_ready", int'(kernel_ready), 0);
      check("rst_busy_done", int'({busy, done}), 0);
      check("rst_cur", int'({cur_oc, cur_ic}), 0);
      check("rst_addr_dout", int'({w_addr, w_dout}), 0);
      rst = 1'b0;
      @(negedge clk);

      for (int v = 0; v < 7; v++)
         run_layer(tbl[v].ic, tbl[v].oc, tbl[v].base, tbl[v].hold,
                   tbl[v].poke, tbl[v].exp_shifts);

      // Reset during FETCH of kernel 3, then a clean rerun.
      begin
         int consumed = 0;
         @(negedge clk);
         in_ch = 6'd2; out_ch = 6'd3; base_addr = 12'h200; start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         for (int n = 0; n < 500 && consumed < 3; n++) begin
            if (kernel_ready) begin
               kernel_consume = 1'b1;
               @(negedge clk);
               kernel_consume = 1'b0;
               consumed++;
            end else begin
               @(negedge clk);
            end
         end
         check("pre_rst_consumed", consumed, 3);
         repeat (3) @(negedge clk);
         check("pre_rst_fetching", int'(w_rd_en), 1);
         check("pre_rst_cur_oc", int'(cur_oc), 1);
         rst = 1'b1;
         @(posedge clk);
         #1;
         check("mid_rst_outputs_zero",
               int'(|{w_rd_en, w_addr, w_dout, w_shift, kernel_ready,
                      cur_oc, cur_ic, busy, done}), 0);
         @(negedge clk);
         rst = 1'b0;
         run_layer(1, 2, 'h040, 0, 1'b0, 18);
      end

      // Randomized layers.
      for (int r = 0; r < 6; r++) begin
         int ric, roc;
         ric = int'($urandom_range(1, 3));
         roc = int'($urandom_range(1, 3));
         run_layer(ric, roc, int'($urandom_range(0, (1 << AW) - 1)),
                   int'($urandom_range(0, 2)), 1'b0, ric * roc * TAPS);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
